gfx_fb_writer: RTL and testbench

Responder end of the gfx pixel stream. Accepts (x, y, color, meta) pixels on a valid/ready handshake, converts each to a linear framebuffer address, and issues one AXI write (AW/W/B) per pixel toward the SRAM framebuffer controller. It sits between any gfx pixel producer (test pattern, line drawer) and the framebuffer AXI slave, and is the write side of the framebuffer that the VGA scanout reads.

---
 rtl/gfx_pkg.sv | 29 ++
 rtl/gfx_fb_writer.sv | 122 ++++++++++++
 tb/tb_gfx_fb_writer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared types, constants and width helpers for the gfx framebuffer write path
`ifndef VGA_MODE_H_VISIBLE
`define VGA_MODE_H_VISIBLE 640
`endif
`ifndef VGA_MODE_V_VISIBLE
`define VGA_MODE_V_VISIBLE 480
`endif

package gfx_pkg;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_XFER,
    ST_RESP
  } fb_state_t;

  // A one-pixel-wide dimension still needs a one-bit coordinate port.
  function automatic int fb_x_bits(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  function automatic int fb_y_bits(input int height);
    return (height > 1) ? $clog2(height) : 1;
  endfunction

endpackage

// File: rtl/gfx_fb_writer.sv
// rtl/gfx_fb_writer.sv - gfx pixel stream responder issuing one AXI write per in-range pixel
module gfx_fb_writer
  import gfx_pkg::*;
#(
  parameter int VGA_WIDTH      = `VGA_MODE_H_VISIBLE,
  parameter int VGA_HEIGHT     = `VGA_MODE_V_VISIBLE,
  parameter int PIXEL_BITS     = 12,
  parameter int META_BITS      = 4,
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16,
  localparam int FB_X_BITS     = fb_x_bits(VGA_WIDTH),
  localparam int FB_Y_BITS     = fb_y_bits(VGA_HEIGHT)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [FB_X_BITS-1:0]          gfx_x,
  input  logic [FB_Y_BITS-1:0]          gfx_y,
  input  logic [PIXEL_BITS-1:0]         gfx_color,
  input  logic [META_BITS-1:0]          gfx_meta,
  input  logic                          gfx_valid,
  output logic                          gfx_ready,
  output logic [AXI_ADDR_WIDTH-1:0]     axi_awaddr,
  output logic                          axi_awvalid,
  input  logic                          axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]     axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   axi_wstrb,
  output logic                          axi_wvalid,
  input  logic                          axi_wready,
  input  logic [1:0]                    axi_bresp,
  input  logic                          axi_bvalid,
  output logic                          axi_bready,
  output logic                          drop_pulse,
  output logic                          resp_err
);

  if (AXI_DATA_WIDTH != PIXEL_BITS + META_BITS) begin : g_bad_data_width
    $error("gfx_fb_writer: AXI_DATA_WIDTH must equal PIXEL_BITS + META_BITS");
  end

  if (longint'(VGA_WIDTH) * longint'(VGA_HEIGHT) > (longint'(1) << AXI_ADDR_WIDTH)) begin : g_bad_addr_width
    $error("gfx_fb_writer: framebuffer does not fit in AXI_ADDR_WIDTH");
  end

  localparam logic [AXI_ADDR_WIDTH-1:0] FB_STRIDE = AXI_ADDR_WIDTH'(VGA_WIDTH);

  fb_state_t                 state;
  logic [FB_X_BITS-1:0]      x_q;
  logic [FB_Y_BITS-1:0]      y_q;
  logic [AXI_DATA_WIDTH-1:0] pix_q;

  logic pix_accept;
  logic pix_in_range;
  logic aw_clear;
  logic w_clear;

  assign pix_accept   = gfx_valid && gfx_ready;
  assign pix_in_range = (int'(gfx_x) < VGA_WIDTH) && (int'(gfx_y) < VGA_HEIGHT);
  // A channel is finished once its valid is low or is being accepted this cycle.
  assign aw_clear     = !axi_awvalid || axi_awready;
  assign w_clear      = !axi_wvalid || axi_wready;
  assign axi_wstrb    = {(AXI_DATA_WIDTH/8){1'b1}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      pix_q       <= '0;
      gfx_ready   <= 1'b0;
      axi_awaddr  <= '0;
      axi_awvalid <= 1'b0;
      axi_wdata   <= '0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      drop_pulse  <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          gfx_ready <= 1'b1;
          if (pix_accept) begin
            x_q   <= gfx_x;
            y_q   <= gfx_y;
            pix_q <= {gfx_meta, gfx_color};
            if (pix_in_range) begin
              gfx_ready <= 1'b0;
              state     <= ST_CALC;
            end else begin
              drop_pulse <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          axi_awaddr  <= AXI_ADDR_WIDTH'(y_q) * FB_STRIDE + AXI_ADDR_WIDTH'(x_q);
          axi_wdata   <= pix_q;
          axi_awvalid <= 1'b1;
          axi_wvalid  <= 1'b1;
          state       <= ST_XFER;
        end
        ST_XFER: begin
          if (axi_awvalid && axi_awready) axi_awvalid <= 1'b0;
          if (axi_wvalid && axi_wready) axi_wvalid <= 1'b0;
          if (aw_clear && w_clear) begin
            axi_bready <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (axi_bvalid && axi_bready) begin
            axi_bready <= 1'b0;
            if (axi_bresp != AXI_RESP_OKAY) resp_err <= 1'b1;
            gfx_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gfx_fb_writer.sv
// tb/tb_gfx_fb_writer.sv - scoreboard bench for gfx_fb_writer with a configurable AXI slave model
module tb_gfx_fb_writer;

  localparam int W = 640;
  localparam int H = 480;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  gfx_x = '0;
  logic [8:0]  gfx_y = '0;
  logic [11:0] gfx_color = '0;
  logic [3:0]  gfx_meta = '0;
  logic        gfx_valid = 1'b0;
  logic        gfx_ready;
  logic [19:0] axi_awaddr;
  logic        axi_awvalid;
  logic        axi_awready = 1'b0;
  logic [15:0] axi_wdata;
  logic [1:0]  axi_wstrb;
  logic        axi_wvalid;
  logic        axi_wready = 1'b0;
  logic [1:0]  axi_bresp = 2'b00;
  logic        axi_bvalid = 1'b0;
  logic        axi_bready;
  logic        drop_pulse;
  logic        resp_err;

  gfx_fb_writer dut (
    .clk        (clk),
    .reset      (reset),
    .gfx_x      (gfx_x),
    .gfx_y      (gfx_y),
    .gfx_color  (gfx_color),
    .gfx_meta   (gfx_meta),
    .gfx_valid  (gfx_valid),
    .gfx_ready  (gfx_ready),
    .axi_awaddr (axi_awaddr),
    .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata  (axi_wdata),
    .axi_wstrb  (axi_wstrb),
    .axi_wvalid (axi_wvalid),
    .axi_wready (axi_wready),
    .axi_bresp  (axi_bresp),
    .axi_bvalid (axi_bvalid),
    .axi_bready (axi_bready),
    .drop_pulse (drop_pulse),
    .resp_err   (resp_err)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Slave model: readies after a programmable wait, one B per completed AW+W pair.
  int         aw_wait = 0, w_wait = 0, aw_cnt = 0, w_cnt = 0, b_count = 0;
  logic [1:0] b_resp_val = 2'b00;
  logic       aw_fire = 0, w_fire = 0, b_fire = 0, aw_done = 0, w_done = 0;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      axi_awready = 0; axi_wready = 0; axi_bvalid = 0;
      aw_cnt = 0; w_cnt = 0; aw_fire = 0; w_fire = 0; b_fire = 0; aw_done = 0; w_done = 0;
    end else begin
      if (aw_fire) aw_done = 1;
      if (w_fire) w_done = 1;
      if (b_fire) begin axi_bvalid = 0; aw_done = 0; w_done = 0; b_count++; end
      if (axi_awvalid) begin axi_awready = (aw_cnt >= aw_wait); aw_cnt++; end
      else begin axi_awready = 0; aw_cnt = 0; end
      if (axi_wvalid) begin axi_wready = (w_cnt >= w_wait); w_cnt++; end
      else begin axi_wready = 0; w_cnt = 0; end
      if (aw_done && w_done && !axi_bvalid) begin axi_bvalid = 1; axi_bresp = b_resp_val; end
      aw_fire = axi_awvalid && axi_awready;
      w_fire  = axi_wvalid && axi_wready;
      b_fire  = axi_bvalid && axi_bready;
    end
  end

  logic [19:0] exp_addr_q[$];
  logic [15:0] exp_data_q[$];

  // Monitor: pairs AW and W beats into one write and checks it against the scoreboard.
  initial begin
    logic [19:0] got_a;
    logic [15:0] got_w;
    logic        have_a, have_w;
    have_a = 0; have_w = 0; got_a = 0; got_w = 0;
    forever begin
      @(negedge clk); #2;
      if (reset) begin
        have_a = 0; have_w = 0;
      end else begin
        if (axi_awvalid && axi_awready) begin got_a = axi_awaddr; have_a = 1; end
        if (axi_wvalid && axi_wready) begin got_w = axi_wdata; have_w = 1; end
        if (have_a && have_w) begin
          if (exp_addr_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_write: got addr %0d data %0h expected no write", got_a, got_w);
          end else begin
            chk("awaddr", 64'(got_a), 64'(exp_addr_q.pop_front()));
            chk("wdata", 64'(got_w), 64'(exp_data_q.pop_front()));
          end
          have_a = 0; have_w = 0;
        end
      end
    end
  end

  task automatic send_px(input int x, input int y, input logic [11:0] c, input logic [3:0] m,
                         output int present_edge);
    int t = 0;
    gfx_x = 10'(x); gfx_y = 9'(y); gfx_color = c; gfx_meta = m; gfx_valid = 1;
    while (gfx_ready !== 1'b1 && t < 40) begin @(posedge clk); #1; t++; end
    present_edge = cyc;
    if (t >= 40) begin
      n_vec++; n_bad++;
      $display("FAIL gfx_accept_timeout: got ready=%0b expected 1 within 40 cycles", gfx_ready);
    end else if (x < W && y < H) begin
      exp_addr_q.push_back(20'(y * W + x));
      exp_data_q.push_back({m, c});
    end
    @(posedge clk); #1;
    gfx_valid = 0;
  endtask

  task automatic watch(input int n, output int aw_hi, output int w_hi, output int drop_hi,
                       output int rdy_lo, output int first_aw, output int first_rdy,
                       output int addr_moves);
    logic [19:0] a0;
    aw_hi = 0; w_hi = 0; drop_hi = 0; rdy_lo = 0; first_aw = -1; first_rdy = -1;
    addr_moves = 0; a0 = '0;
    for (int i = 0; i < n; i++) begin
      if (axi_awvalid) begin
        if (aw_hi == 0) begin first_aw = cyc; a0 = axi_awaddr; end
        else if (axi_awaddr !== a0) addr_moves++;
        aw_hi++;
      end
      if (axi_wvalid) w_hi++;
      if (drop_pulse) drop_hi++;
      if (!gfx_ready) rdy_lo++;
      else if (first_rdy < 0) first_rdy = cyc;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int p, aw_hi, w_hi, drop_hi, rdy_lo, first_aw, first_rdy, moves, b0, t;
    int pe[10];

    repeat (3) @(posedge clk);
    #1;
    chk("reset_gfx_ready", 64'(gfx_ready), 0);
    chk("reset_valids", 64'({axi_awvalid, axi_wvalid, axi_bready}), 0);
    chk("reset_addr_data", 64'({axi_awaddr, axi_wdata}), 0);
    chk("reset_drop_err", 64'({drop_pulse, resp_err}), 0);
    reset = 0;
    @(posedge clk); #1;
    chk("release_gfx_ready", 64'(gfx_ready), 1);
    chk("wstrb", 64'(axi_wstrb), 64'(2'b11));

    // Single pixel, zero-wait slave
    b0 = b_count;
    send_px(3, 2, 12'hABC, 4'h5, p);
    watch(8, aw_hi, w_hi, drop_hi, rdy_lo, first_aw, first_rdy, moves);
    chk("single_aw_latency", 64'(first_aw), 64'(p + 2));
    chk("single_ready_back", 64'(first_rdy), 64'(p + 4));
    chk("single_aw_cycles", 64'(aw_hi), 1);
    chk("single_b_count", 64'(b_count - b0), 1);
    chk("single_resp_err", 64'(resp_err), 0);

    // awready delayed 3 cycles, wready immediate
    aw_wait = 3; b0 = b_count;
    send_px(10, 1, 12'h123, 4'hA, p);
    watch(12, aw_hi, w_hi, drop_hi, rdy_lo, first_aw, first_rdy, moves);
    chk("slow_aw_cycles", 64'(aw_hi), 4);
    chk("slow_w_cycles", 64'(w_hi), 1);
    chk("slow_addr_stable", 64'(moves), 0);
    chk("slow_ready_back", 64'(first_rdy), 64'(p + 7));
    chk("slow_b_count", 64'(b_count - b0), 1);
    aw_wait = 0;

    // Out-of-range pixels are dropped with no AXI traffic
    send_px(640, 0, 12'hFFF, 4'hF, p);
    watch(6, aw_hi, w_hi, drop_hi, rdy_lo, first_aw, first_rdy, moves);
    chk("drop_x_pulse", 64'(drop_hi), 1);
    chk("drop_x_no_axi", 64'(aw_hi + w_hi), 0);
    chk("drop_x_ready_held", 64'(rdy_lo), 0);
    send_px(0, 480, 12'h111, 4'h1, p);
    watch(6, aw_hi, w_hi, drop_hi, rdy_lo, first_aw, first_rdy, moves);
    chk("drop_y_pulse", 64'(drop_hi), 1);
    chk("drop_y_no_axi", 64'(aw_hi + w_hi), 0);

    // Framebuffer corners: addresses 0 and 307199
    send_px(0, 0, 12'h000, 4'h0, p);
    watch(8, aw_hi, w_hi, drop_hi, rdy_lo, first_aw, first_rdy, moves);
    send_px(639, 479, 12'hFED, 4'hC, p);
    watch(8, aw_hi, w_hi, drop_hi, rdy_lo, first_aw, first_rdy, moves);

    // SLVERR response makes resp_err sticky
    b_resp_val = 2'b10;
    send_px(5, 5, 12'h0F0, 4'h3, p);
    watch(8, aw_hi, w_hi, drop_hi, rdy_lo, first_aw, first_rdy, moves);
    chk("resp_err_set", 64'(resp_err), 1);
    b_resp_val = 2'b00;
    send_px(6, 5, 12'h00F, 4'h2, p);
    watch(8, aw_hi, w_hi, drop_hi, rdy_lo, first_aw, first_rdy, moves);
    chk("resp_err_sticky", 64'(resp_err), 1);

    // Back-to-back stream of 10 pixels
    b0 = b_count;
    for (int i = 0; i < 10; i++) send_px(100 + 7 * i, 10 + i, 12'(12'h200 + i), 4'(i), pe[i]);
    for (int i = 1; i < 10; i++) chk($sformatf("stream_gap_%0d", i), 64'(pe[i] - pe[i-1]), 4);
    watch(8, aw_hi, w_hi, drop_hi, rdy_lo, first_aw, first_rdy, moves);
    chk("stream_b_count", 64'(b_count - b0), 10);

    // Reset while stuck in XFER
    aw_wait = 5;
    send_px(20, 30, 12'h777, 4'h7, p);
    @(posedge clk); #1;
    chk("xfer_awvalid_before_reset", 64'(axi_awvalid), 1);
    #2 reset = 1;
    #1;
    chk("reset_mid_valids", 64'({axi_awvalid, axi_wvalid, axi_bready}), 0);
    chk("reset_mid_gfx_ready", 64'(gfx_ready), 0);
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    aw_wait = 0;
    b0 = b_count;
    watch(10, aw_hi, w_hi, drop_hi, rdy_lo, first_aw, first_rdy, moves);
    chk("post_reset_no_axi", 64'(aw_hi + w_hi), 0);
    chk("post_reset_ready_lo", 64'(rdy_lo), 1);
    chk("post_reset_no_b", 64'(b_count - b0), 0);
    send_px(1, 1, 12'h321, 4'h9, p);
    watch(8, aw_hi, w_hi, drop_hi, rdy_lo, first_aw, first_rdy, moves);
    chk("post_reset_write", 64'(b_count - b0), 1);

    t = 0;
    while (exp_addr_q.size() != 0 && t < 50) begin @(posedge clk); #1; t++; end
    chk("scoreboard_drained", 64'(exp_addr_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
